gpu_blitter: RTL
================

GPU_BLITTER -- requirements
Module: gpu_blitter

Interface
REQ-001 Parameter FB_BASE, default 4096, SHALL be the bus address of framebuffer cell 0.
REQ-002 Parameter FB_COLS, default 80, SHALL be the framebuffer width in cells.
REQ-003 Parameter FB_ROWS, default 60, SHALL be the framebuffer height in cells.
REQ-004 Parameter STROBE_CYCLES, default 4 (min 1), SHALL be the clocks BUS_CE is held low per bus access.
REQ-005 Parameter GAP_CYCLES, default 2 (min 1), SHALL be the clocks BUS_CE is held high between accesses.
REQ-006 Ports SHALL be:
  CLK_SYS  in  1  sole clock; one clock; all logic on its rising edge.
  RESET  in  1  synchronous, active-high reset.
  CMD_VALID  in  1  command offered.
  CMD_READY  out  1  engine idle; command accepted when VALID&&READY.
  CMD_SWAP  in  1  1 = buffer-swap command; 0 = rectangle fill.
  CMD_X, CMD_Y  in  7 each  top-left cell.
  CMD_W, CMD_H  in  7 each  rectangle size in cells.
  CMD_COLOR  in  3  fill colour {B,G,R}.
  DONE  out  1  one-clock pulse when a command completes.
  BUS_CE  out  1  active-low chip enable.
  BUS_RW  out  1  1 = read, 0 = write.
  BUS_ADDR  out  15  bus address.
  BUS_DOUT  out  7  write data.
  BUS_DOE  out  1  drive BUS_DOUT onto the shared data bus.
  BUS_DIN  in  7  read data; bit 0 = framebuffer VSYNC.

Function
REQ-007 In IDLE, the engine SHALL drive CMD_READY=1, BUS_CE=1, BUS_RW=1, BUS_DOE=0, and hold BUS_ADDR and BUS_DOUT at 0.
REQ-008 On acceptance, the engine SHALL latch all CMD_* inputs and deassert CMD_READY on the next clock; CMD_VALID while busy SHALL be ignored.
REQ-009 The state machine SHALL use the states IDLE, SETUP, STROBE, GAP, POLL, SWAP and FINISH.
REQ-010 Fill: SETUP SHALL clip the rectangle to x_end=min(X+W,FB_COLS) and y_end=min(Y+H,FB_ROWS).
REQ-011 Fill: if W=0, H=0, X>=FB_COLS or Y>=FB_ROWS, the engine SHALL go directly to FINISH with no bus access.
REQ-012 Fill: cells SHALL be written in row-major order, x fastest.
REQ-013 Fill: each cell write SHALL take STROBE_CYCLES clocks in STROBE then GAP_CYCLES clocks in GAP.
REQ-014 During STROBE, BUS_CE SHALL be 0, BUS_RW=0, BUS_DOE=1, BUS_ADDR=FB_BASE+y*FB_COLS+x (15-bit truncation), and BUS_DOUT={4'b0000,COLOR}.
REQ-015 Write data bit 6 SHALL always be 0 during a fill.
REQ-016 BUS_ADDR, BUS_DOUT and BUS_DOE SHALL be stable for the whole STROBE and change only in GAP or IDLE.
REQ-017 After the last cell's GAP, the engine SHALL enter FINISH; FINISH SHALL pulse DONE for one clock and then return to IDLE with CMD_READY=1.
REQ-018 Swap: the engine SHALL perform one write access with BUS_DOUT=7'b1000000 and BUS_ADDR=FB_BASE, using the same STROBE/GAP timing, then enter FINISH.
REQ-019 Total latency of an unclipped fill SHALL be 1 (accept) + 1 (SETUP) + W*H*(STROBE_CYCLES+GAP_CYCLES) + 1 (FINISH) clocks until DONE.

Reset
REQ-020 RESET=1 at any clock edge, including mid-strobe, SHALL force IDLE on that edge with all outputs at their REQ-007 values and DONE=0.
REQ-021 A command interrupted by RESET SHALL be discarded, with no DONE pulse.

Configuration
REQ-022 With BLIT_VSYNC_WAIT_EN defined, a swap command SHALL first enter POLL.
REQ-023 POLL SHALL issue read accesses (BUS_CE=0, BUS_RW=1, BUS_DOE=0, BUS_ADDR=FB_BASE) of STROBE_CYCLES clocks, followed by GAP_CYCLES clocks.
REQ-024 POLL SHALL sample BUS_DIN[0] on the last clock of each read strobe and proceed to SWAP only when the sample is 0 (VSYNC active-low); otherwise it SHALL repeat the read.
REQ-025 Without BLIT_VSYNC_WAIT_EN, the POLL state and its logic SHALL be absent, and a swap SHALL go from SETUP directly to SWAP.

Structure
REQ-026 A shared package gpu_pkg SHALL hold the state enum, the FB_BASE/FB_COLS/FB_ROWS defaults, the colour typedef (3 bits), and the SWAP_CMD constant (7'h40).
REQ-027 One sub-module, gpu_bus_strobe, SHALL generate one timed access (start, rw, addr, data -> CE/RW/DOE/busy/sample strobe); gpu_blitter SHALL instantiate it once.

Verification
REQ-028 Fill X=2,Y=3,W=2,H=2,COLOR=5 -> writes addr 4338,4339,4418,4419 with DOUT=7'h05, then DONE; checks REQ-019 latency of 27 clocks at default parameters.
REQ-029 Fill X=79,Y=59,W=4,H=4 -> exactly one write to addr 8895, then DONE.
REQ-030 Fill with W=0 -> no BUS_CE low, DONE 3 clocks after acceptance.
REQ-031 Swap without BLIT_VSYNC_WAIT_EN -> one write of DOUT=7'h40 to addr 4096, then DONE.
REQ-032 Swap with BLIT_VSYNC_WAIT_EN and BUS_DIN[0] held 1 for 3 polls, then 0 -> exactly 4 reads, then the swap write, then DONE.
REQ-033 RESET asserted during a STROBE of a fill -> next edge shows BUS_CE=1, BUS_DOE=0, CMD_READY=1, with no DONE pulse.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared types, defaults and address helper for the gpu_blitter engine.
package gpu_pkg;

   localparam int DEF_FB_BASE = 4096;
   localparam int DEF_FB_COLS = 80;
   localparam int DEF_FB_ROWS = 60;

   // Bit 6 set marks the buffer-swap write; fills never set it.
   localparam logic [6:0] SWAP_CMD = 7'h40;

   typedef logic [2:0] color_t;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STROBE,
      GAP,
      POLL,
      SWAP,
      FINISH
   } blit_state_e;

   function automatic logic [14:0] cell_addr(input int base, input int cols,
                                             input logic [6:0] x, input logic [6:0] y);
      int a;
      a = base + int'(y) * cols + int'(x);
      return a[14:0];
   endfunction

endpackage

// File: rtl/gpu_bus_strobe.sv
// One timed bus access: STROBE_CYCLES with CE low, then GAP_CYCLES with CE high.
// Latency: CE falls the clock after start_i. A start_i on the last gap clock chains the next access.
// Backpressure: none; the caller waits for last_o before starting another access.
module gpu_bus_strobe #(
   parameter int STROBE_CYCLES = 4,
   parameter int GAP_CYCLES    = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        rw_i,
   input  logic [14:0] addr_i,
   input  logic [6:0]  data_i,
   output logic        ce_o,
   output logic        rw_o,
   output logic        doe_o,
   output logic [14:0] addr_o,
   output logic [6:0]  dout_o,
   output logic        busy_o,
   output logic        sample_o,
   output logic        last_o
);

   logic        act_q, act_d;
   logic        gap_q, gap_d;
   logic [15:0] cnt_q, cnt_d;
   logic        rw_q, rw_d;
   logic [14:0] addr_q, addr_d;
   logic [6:0]  data_q, data_d;
   logic        strobe_end;
   logic        gap_end;

   assign strobe_end = act_q && !gap_q && (cnt_q == 16'(STROBE_CYCLES - 1));
   assign gap_end    = act_q &&  gap_q && (cnt_q == 16'(GAP_CYCLES - 1));

   always_comb begin
      act_d  = act_q;
      gap_d  = gap_q;
      cnt_d  = cnt_q;
      rw_d   = rw_q;
      addr_d = addr_q;
      data_d = data_q;
      if (start_i) begin
         act_d  = 1'b1;
         gap_d  = 1'b0;
         cnt_d  = '0;
         rw_d   = rw_i;
         addr_d = addr_i;
         data_d = data_i;
      end else if (strobe_end) begin
         gap_d = 1'b1;
         cnt_d = '0;
      end else if (gap_end) begin
         // Returning to the idle bus values keeps ADDR/DOUT at zero between commands.
         act_d  = 1'b0;
         gap_d  = 1'b0;
         cnt_d  = '0;
         rw_d   = 1'b1;
         addr_d = '0;
         data_d = '0;
      end else if (act_q) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         act_q  <= 1'b0;
         gap_q  <= 1'b0;
         cnt_q  <= '0;
         rw_q   <= 1'b1;
         addr_q <= '0;
         data_q <= '0;
      end else begin
         act_q  <= act_d;
         gap_q  <= gap_d;
         cnt_q  <= cnt_d;
         rw_q   <= rw_d;
         addr_q <= addr_d;
         data_q <= data_d;
      end
   end

   assign ce_o     = !(act_q && !gap_q);
   assign rw_o     = rw_q;
   assign doe_o    = act_q && !rw_q;
   assign addr_o   = addr_q;
   assign dout_o   = data_q;
   assign busy_o   = act_q;
   assign sample_o = strobe_end;
   assign last_o   = gap_end;

endmodule

// File: rtl/gpu_blitter.sv
// Rectangle-fill / buffer-swap engine writing framebuffer cells over a strobed bus; optional BLIT_VSYNC_WAIT_EN polls VSYNC before a swap.
// Latency: DONE 1+1+W*H*(STROBE_CYCLES+GAP_CYCLES)+1 clocks after accept for an unclipped fill.
// Backpressure: CMD_READY only in IDLE; CMD_VALID while busy is ignored.
module gpu_blitter
   import gpu_pkg::*;
#(
   parameter int FB_BASE       = DEF_FB_BASE,
   parameter int FB_COLS       = DEF_FB_COLS,
   parameter int FB_ROWS       = DEF_FB_ROWS,
   parameter int STROBE_CYCLES = 4,
   parameter int GAP_CYCLES    = 2
) (
   input  logic        CLK_SYS,
   input  logic        RESET,
   input  logic        CMD_VALID,
   output logic        CMD_READY,
   input  logic        CMD_SWAP,
   input  logic [6:0]  CMD_X,
   input  logic [6:0]  CMD_Y,
   input  logic [6:0]  CMD_W,
   input  logic [6:0]  CMD_H,
   input  logic [2:0]  CMD_COLOR,
   output logic        DONE,
   output logic        BUS_CE,
   output logic        BUS_RW,
   output logic [14:0] BUS_ADDR,
   output logic [6:0]  BUS_DOUT,
   output logic        BUS_DOE,
   input  logic [6:0]  BUS_DIN
);

   localparam logic [14:0] BASE_ADDR = 15'(FB_BASE);

   blit_state_e state_q, state_d;
   logic        swap_q, swap_d;
   logic [6:0]  x_q, x_d, y_q, y_d, xs_q, xs_d, w_q, w_d, h_q, h_d;
   logic [7:0]  xe_q, xe_d, ye_q, ye_d;
   color_t      color_q, color_d;

   logic        acc_start, acc_rw, acc_busy, acc_sample, acc_last;
   logic [14:0] acc_addr;
   logic [6:0]  acc_data;
   logic [7:0]  xsum, ysum, xn, yn;
   logic        fill_empty;

`ifdef BLIT_VSYNC_WAIT_EN
   logic vs_q, vs_d;
   logic unused_din;
   assign unused_din = ^BUS_DIN[6:1];
`else
   logic unused_din;
   assign unused_din = ^BUS_DIN;
`endif

   assign xsum = {1'b0, x_q} + {1'b0, w_q};
   assign ysum = {1'b0, y_q} + {1'b0, h_q};
   assign xn   = {1'b0, x_q} + 8'd1;
   assign yn   = {1'b0, y_q} + 8'd1;
   assign fill_empty = (w_q == '0) || (h_q == '0) ||
                       (int'(x_q) >= FB_COLS) || (int'(y_q) >= FB_ROWS);

   always_comb begin
      state_d   = state_q;
      swap_d    = swap_q;
      x_d       = x_q;
      y_d       = y_q;
      xs_d      = xs_q;
      w_d       = w_q;
      h_d       = h_q;
      xe_d      = xe_q;
      ye_d      = ye_q;
      color_d   = color_q;
`ifdef BLIT_VSYNC_WAIT_EN
      vs_d      = vs_q;
`endif
      acc_start = 1'b0;
      acc_rw    = 1'b0;
      acc_addr  = cell_addr(FB_BASE, FB_COLS, x_q, y_q);
      acc_data  = {4'b0000, color_q};
      unique case (state_q)
         IDLE: begin
            if (CMD_VALID && CMD_READY) begin
               swap_d  = CMD_SWAP;
               x_d     = CMD_X;
               xs_d    = CMD_X;
               y_d     = CMD_Y;
               w_d     = CMD_W;
               h_d     = CMD_H;
               color_d = CMD_COLOR;
               state_d = SETUP;
            end
         end
         SETUP: begin
            xe_d = (int'(xsum) > FB_COLS) ? 8'(FB_COLS) : xsum;
            ye_d = (int'(ysum) > FB_ROWS) ? 8'(FB_ROWS) : ysum;
            if (swap_q) begin
               acc_start = 1'b1;
               acc_addr  = BASE_ADDR;
`ifdef BLIT_VSYNC_WAIT_EN
               acc_rw    = 1'b1;
               state_d   = POLL;
`else
               acc_data  = SWAP_CMD;
               state_d   = SWAP;
`endif
            end else if (fill_empty) begin
               state_d = FINISH;
            end else begin
               acc_start = 1'b1;
               state_d   = STROBE;
            end
         end
         STROBE: begin
            if (acc_sample) state_d = GAP;
         end
         GAP: begin
            if (acc_last) begin
               // Row-major walk; the next access chains straight off the gap.
               if (xn < xe_q) begin
                  x_d       = xn[6:0];
                  acc_start = 1'b1;
                  acc_addr  = cell_addr(FB_BASE, FB_COLS, xn[6:0], y_q);
                  state_d   = STROBE;
               end else if (yn < ye_q) begin
                  x_d       = xs_q;
                  y_d       = yn[6:0];
                  acc_start = 1'b1;
                  acc_addr  = cell_addr(FB_BASE, FB_COLS, xs_q, yn[6:0]);
                  state_d   = STROBE;
               end else begin
                  state_d = FINISH;
               end
            end
         end
`ifdef BLIT_VSYNC_WAIT_EN
         POLL: begin
            if (acc_sample) vs_d = BUS_DIN[0];
            if (acc_last) begin
               acc_start = 1'b1;
               acc_addr  = BASE_ADDR;
               if (!vs_q) begin
                  acc_data = SWAP_CMD;
                  state_d  = SWAP;
               end else begin
                  acc_rw = 1'b1;
               end
            end
         end
`endif
         SWAP: begin
            if (acc_last) state_d = FINISH;
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK_SYS) begin
      if (RESET) begin
         state_q <= IDLE;
         swap_q  <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         xs_q    <= '0;
         w_q     <= '0;
         h_q     <= '0;
         xe_q    <= '0;
         ye_q    <= '0;
         color_q <= '0;
`ifdef BLIT_VSYNC_WAIT_EN
         vs_q    <= 1'b1;
`endif
      end else begin
         state_q <= state_d;
         swap_q  <= swap_d;
         x_q     <= x_d;
         y_q     <= y_d;
         xs_q    <= xs_d;
         w_q     <= w_d;
         h_q     <= h_d;
         xe_q    <= xe_d;
         ye_q    <= ye_d;
         color_q <= color_d;
`ifdef BLIT_VSYNC_WAIT_EN
         vs_q    <= vs_d;
`endif
      end
   end

   gpu_bus_strobe #(
      .STROBE_CYCLES(STROBE_CYCLES),
      .GAP_CYCLES   (GAP_CYCLES)
   ) u_strobe (
      .clk_i   (CLK_SYS),
      .rst_i   (RESET),
      .start_i (acc_start),
      .rw_i    (acc_rw),
      .addr_i  (acc_addr),
      .data_i  (acc_data),
      .ce_o    (BUS_CE),
      .rw_o    (BUS_RW),
      .doe_o   (BUS_DOE),
      .addr_o  (BUS_ADDR),
      .dout_o  (BUS_DOUT),
      .busy_o  (acc_busy),
      .sample_o(acc_sample),
      .last_o  (acc_last)
   );

   assign CMD_READY = (state_q == IDLE) && !acc_busy;
   assign DONE      = (state_q == FINISH);

endmodule
